// File: rtl/alu_rs_pkg.sv
// Shared ALU function codes and reservation-station entry layout for alu_rs.
// Tags are stored at TAG_MAX width; instances use TAG_W <= TAG_MAX.
package alu_rs_pkg;

  localparam int TAG_MAX = 8;

  localparam logic [4:0] FN_AND  = 5'h00;
  localparam logic [4:0] FN_OR   = 5'h01;
  localparam logic [4:0] FN_XOR  = 5'h02;
  localparam logic [4:0] FN_ADD  = 5'h03;
  localparam logic [4:0] FN_SUB  = 5'h04;
  localparam logic [4:0] FN_SLL  = 5'h05;
  localparam logic [4:0] FN_SRL  = 5'h06;
  localparam logic [4:0] FN_SRA  = 5'h07;
  localparam logic [4:0] FN_SLT  = 5'h08;
  localparam logic [4:0] FN_SLTU = 5'h09;
  localparam logic [4:0] FN_MIN  = 5'h0A;
  localparam logic [4:0] FN_MAX  = 5'h0B;
  localparam logic [4:0] FN_CLZ  = 5'h10;
  localparam logic [4:0] FN_CTZ  = 5'h11;
  localparam logic [4:0] FN_CPOP = 5'h12;

  typedef struct packed {
    logic               rdy;
    logic [TAG_MAX-1:0] tag;
    logic [31:0]        val;
  } rs_src_t;

  typedef struct packed {
    logic               valid;
    logic [4:0]         func;
    logic [TAG_MAX-1:0] dst_tag;
    rs_src_t            src1;
    rs_src_t            src2;
  } rs_entry_t;

  // Capture a matching broadcast into a waiting operand.
  function automatic rs_src_t snoop(input rs_src_t s, input logic cv,
                                    input logic [TAG_MAX-1:0] ct, input logic [31:0] cd);
    rs_src_t r;
    r = s;
    if (!s.rdy && cv && (s.tag == ct)) begin
      r.rdy = 1'b1;
      r.val = cd;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_rs_select.sv
// Issue selection: one-hot grant among ready entries.
// RS_OLDEST_FIRST_EN selects by age matrix, otherwise lowest index wins.
module rs_select #(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0]            rdy_i,
`ifdef RS_OLDEST_FIRST_EN
  input  logic [DEPTH-1:0][DEPTH-1:0] older_i,
`endif
  output logic [DEPTH-1:0]            gnt_o,
  output logic                        any_o
);

`ifdef RS_OLDEST_FIRST_EN
  // older_i[j][i] set means entry j was dispatched before entry i.
  always_comb begin
    gnt_o = '0;
    any_o = |rdy_i;
    for (int i = 0; i < DEPTH; i++) begin
      gnt_o[i] = rdy_i[i];
      for (int j = 0; j < DEPTH; j++) begin
        if ((j != i) && rdy_i[j] && older_i[j][i]) gnt_o[i] = 1'b0;
      end
    end
  end
`else
  logic found;
  always_comb begin
    gnt_o = '0;
    any_o = |rdy_i;
    found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rdy_i[i] && !found) begin
        gnt_o[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: dispatch into free entries, CDB snoop, single issue.
// RS_OLDEST_FIRST_EN enables oldest-first issue via a per-entry age matrix.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [4:0]       disp_func,
  input  logic [TAG_W-1:0] disp_dst_tag,
  input  logic             disp_src1_rdy,
  input  logic [31:0]      disp_src1_val,
  input  logic [TAG_W-1:0] disp_src1_tag,
  input  logic             disp_src2_rdy,
  input  logic [31:0]      disp_src2_val,
  input  logic [TAG_W-1:0] disp_src2_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  output logic             iss_valid,
  input  logic             iss_ready,
  output logic [31:0]      iss_src1,
  output logic [31:0]      iss_src2,
  output logic [4:0]       iss_func,
  output logic [TAG_W-1:0] iss_dst_tag
);

  rs_entry_t [DEPTH-1:0] ent_q, ent_d;
  logic                  lock_q, lock_d;
  logic [DEPTH-1:0]      lock_gnt_q, lock_gnt_d;
  logic [DEPTH-1:0]      vld, rdy, alloc_oh, sel_gnt, gnt;
  logic                  sel_any, alloc_found, disp_fire;
  logic [TAG_MAX-1:0]    cdb_tag_x;
  rs_entry_t             new_ent, sel_ent;

  always_comb begin
    vld         = '0;
    rdy         = '0;
    alloc_oh    = '0;
    alloc_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      vld[i] = ent_q[i].valid;
      rdy[i] = ent_q[i].valid && ent_q[i].src1.rdy && ent_q[i].src2.rdy;
      if (!ent_q[i].valid && !alloc_found) begin
        alloc_oh[i] = 1'b1;
        alloc_found = 1'b1;
      end
    end
  end

  assign disp_ready = alloc_found;
  assign disp_fire  = disp_valid && disp_ready && !flush;
  assign cdb_tag_x  = TAG_MAX'(cdb_tag);

`ifdef RS_OLDEST_FIRST_EN
  logic [DEPTH-1:0][DEPTH-1:0] older_q, older_d;

  always_comb begin
    older_d = older_q;
    if (flush) begin
      older_d = '0;
    end else if (disp_fire) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (alloc_oh[k]) begin
          for (int j = 0; j < DEPTH; j++) begin
            older_d[k][j] = 1'b0;
            older_d[j][k] = vld[j];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) older_q <= '0;
    else     older_q <= older_d;
  end

  rs_select #(.DEPTH(DEPTH)) u_sel (
    .rdy_i   (rdy),
    .older_i (older_q),
    .gnt_o   (sel_gnt),
    .any_o   (sel_any)
  );
`else
  rs_select #(.DEPTH(DEPTH)) u_sel (
    .rdy_i (rdy),
    .gnt_o (sel_gnt),
    .any_o (sel_any)
  );
`endif

  // A stalled issue is pinned so later wakeups cannot change the offered entry.
  always_comb begin
    gnt       = lock_q ? lock_gnt_q : sel_gnt;
    iss_valid = lock_q || sel_any;
    sel_ent   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (gnt[i]) sel_ent = ent_q[i];
    end
    iss_src1    = sel_ent.src1.val;
    iss_src2    = sel_ent.src2.val;
    iss_func    = sel_ent.func;
    iss_dst_tag = TAG_W'(sel_ent.dst_tag);
  end

  always_comb begin
    new_ent          = '0;
    new_ent.valid    = 1'b1;
    new_ent.func     = disp_func;
    new_ent.dst_tag  = TAG_MAX'(disp_dst_tag);
    new_ent.src1.rdy = disp_src1_rdy;
    new_ent.src1.tag = TAG_MAX'(disp_src1_tag);
    new_ent.src1.val = disp_src1_val;
    new_ent.src2.rdy = disp_src2_rdy;
    new_ent.src2.tag = TAG_MAX'(disp_src2_tag);
    new_ent.src2.val = disp_src2_val;
    new_ent.src1     = snoop(new_ent.src1, cdb_valid, cdb_tag_x, cdb_data);
    new_ent.src2     = snoop(new_ent.src2, cdb_valid, cdb_tag_x, cdb_data);

    ent_d = ent_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].valid) begin
        ent_d[i].src1 = snoop(ent_q[i].src1, cdb_valid, cdb_tag_x, cdb_data);
        ent_d[i].src2 = snoop(ent_q[i].src2, cdb_valid, cdb_tag_x, cdb_data);
      end
      if (iss_valid && iss_ready && gnt[i]) ent_d[i] = '0;
      if (disp_fire && alloc_oh[i])         ent_d[i] = new_ent;
    end
    if (flush) ent_d = '0;

    lock_d     = iss_valid && !iss_ready && !flush;
    lock_gnt_d = lock_d ? gnt : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q      <= '0;
      lock_q     <= 1'b0;
      lock_gnt_q <= '0;
    end else begin
      ent_q      <= ent_d;
      lock_q     <= lock_d;
      lock_gnt_q <= lock_gnt_d;
    end
  end

endmodule
